tagged_memory: RTL and testbench

TAGGED_MEMORY -- requirements
Module: tagged_memory

---
 rtl/tmem_pkg.sv | 22 ++
 rtl/tagged_ram_core.sv | 44 ++++
 rtl/tagged_memory.sv | 81 ++++++++
 tb/tb_tagged_memory.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tmem_pkg.sv
// Shared widths and entry layout for the tagged memory slice.
// Every stored word carries its tag alongside its data.
package tmem_pkg;

  localparam int TMEM_ADDR_W = 20;
  localparam int TMEM_DATA_W = 64;
  localparam int TMEM_TAG_W  = 8;

  typedef struct packed {
    logic [TMEM_TAG_W-1:0]  tag;
    logic [TMEM_DATA_W-1:0] data;
  } entry_t;

  function automatic entry_t make_entry(input logic [TMEM_TAG_W-1:0]  tag,
                                        input logic [TMEM_DATA_W-1:0] data);
    entry_t e;
    e.tag  = tag;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/tagged_ram_core.sv
// Single-port synchronous RAM with a registered, resettable read port.
// A read and a write on the same edge see the old contents (read-before-write).
module tagged_ram_core #(
  parameter int ADDR_W  = 20,
  parameter int ENTRY_W = 72
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ENTRY_W-1:0] rdata_q;
  logic [ENTRY_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately never cleared; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/tagged_memory.sv
// Tagged word memory: strobed address latch, read-modify-write lock and
// request steering around a single-port read-before-write RAM.
module tagged_memory
  import tmem_pkg::*;
#(
  parameter int ADDR_W = TMEM_ADDR_W,
  parameter int DATA_W = TMEM_DATA_W,
  parameter int TAG_W  = TMEM_TAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_ad,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_astb,
  input  logic              i_atomic,
  input  logic              i_rd,
  input  logic              i_wr,
  output logic [DATA_W-1:0] o_data,
  output logic [TAG_W-1:0]  o_tag,
  output logic [ADDR_W-1:0] waddr
);

  localparam int ENTRY_W = DATA_W + TAG_W;

  logic [ADDR_W-1:0]  waddr_q;
  logic [ADDR_W-1:0]  waddr_d;
  logic               lock_q;
  logic               lock_d;
  logic [ADDR_W-1:0]  strobe_addr;
  logic [ADDR_W-1:0]  ram_addr;
  logic               rd_en;
  logic               wr_en;
  logic [ENTRY_W-1:0] ram_wdata;
  logic [ENTRY_W-1:0] ram_rdata;

  // A strobe cycle carries an address on i_ad, so it can never be a write;
  // reads in that cycle use the fresh address rather than the latched one.
  always_comb begin
    strobe_addr = i_ad[ADDR_W-1:0];
    rd_en       = i_rd & ~reset;
    wr_en       = i_wr & ~i_astb & ~reset;
    ram_addr    = i_astb ? strobe_addr : waddr_q;
    ram_wdata   = {i_tag, i_ad};
    waddr_d     = waddr_q;
    lock_d      = lock_q;
    if (i_astb) begin
      waddr_d = strobe_addr;
      lock_d  = i_atomic;
    end else if (wr_en) begin
      lock_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      waddr_q <= '0;
      lock_q  <= 1'b0;
    end else begin
      waddr_q <= waddr_d;
      lock_q  <= lock_d;
    end
  end

  tagged_ram_core #(
    .ADDR_W  (ADDR_W),
    .ENTRY_W (ENTRY_W)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .rd_en (rd_en),
    .wr_en (wr_en),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign o_data = ram_rdata[DATA_W-1:0];
  assign o_tag  = ram_rdata[ENTRY_W-1 -: TAG_W];
  assign waddr  = waddr_q;

endmodule

// File: tb/tb_tagged_memory.sv
// Bench for tagged_memory: directed vector table followed by randomized
// traffic checked against a behavioural model of the memory.
module tb_tagged_memory;
  import tmem_pkg::*;

  logic        clk;
  logic        reset;
  logic [63:0] i_ad;
  logic [7:0]  i_tag;
  logic        i_astb;
  logic        i_atomic;
  logic        i_rd;
  logic        i_wr;
  logic [63:0] o_data;
  logic [7:0]  o_tag;
  logic [19:0] waddr;

  int n_pass;
  int n_total;

  // Behavioural model state
  entry_t      m_mem [bit [19:0]];
  logic [19:0] m_waddr;
  logic        m_lock;
  entry_t      m_out;

  typedef struct {
    bit          rst;
    bit          astb;
    bit          atomic;
    bit          rd;
    bit          wr;
    logic [63:0] ad;
    logic [7:0]  tag;
    logic [19:0] ew;
    logic [63:0] ed;
    logic [7:0]  et;
  } vec_t;

  vec_t vecs[$];

  tagged_memory dut (
    .clk      (clk),
    .reset    (reset),
    .i_ad     (i_ad),
    .i_tag    (i_tag),
    .i_astb   (i_astb),
    .i_atomic (i_atomic),
    .i_rd     (i_rd),
    .i_wr     (i_wr),
    .o_data   (o_data),
    .o_tag    (o_tag),
    .waddr    (waddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic entry_t model_read(input logic [19:0] a);
    if (m_mem.exists(a)) return m_mem[a];
    return '0;
  endfunction

  // One clock of the model, following the behavioural rules directly.
  task automatic model_step(input bit rst, input bit astb, input bit atomic,
                            input bit rd, input bit wr,
                            input logic [63:0] ad, input logic [7:0] tag);
    logic [19:0] raddr;
    if (rst) begin
      m_waddr = '0;
      m_lock  = 1'b0;
      m_out   = '0;
      return;
    end
    raddr = astb ? ad[19:0] : m_waddr;
    if (rd) m_out = model_read(raddr);
    if (wr && !astb) begin
      m_mem[m_waddr] = make_entry(tag, ad);
      m_lock = 1'b0;
    end
    if (astb) begin
      m_waddr = ad[19:0];
      m_lock  = atomic;
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit astb, input bit atomic,
                               input bit rd, input bit wr,
                               input logic [63:0] ad, input logic [7:0] tag);
    reset    = rst;
    i_astb   = astb;
    i_atomic = atomic;
    i_rd     = rd;
    i_wr     = wr;
    i_ad     = ad;
    i_tag    = tag;
    @(posedge clk);
    #1;
    model_step(rst, astb, atomic, rd, wr, ad, tag);
    reset = 1'b0; i_astb = 1'b0; i_atomic = 1'b0; i_rd = 1'b0; i_wr = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [19:0] ew,
                             input logic [63:0] ed, input logic [7:0] et);
    n_total++;
    if (waddr === ew) n_pass++;
    else $display("[TB] FAIL %s waddr: got %h expected %h", name, waddr, ew);
    n_total++;
    if (o_data === ed) n_pass++;
    else $display("[TB] FAIL %s o_data: got %h expected %h", name, o_data, ed);
    n_total++;
    if (o_tag === et) n_pass++;
    else $display("[TB] FAIL %s o_tag: got %h expected %h", name, o_tag, et);
  endtask

  function automatic void add(input bit rst, input bit astb, input bit atomic,
                              input bit rd, input bit wr,
                              input logic [63:0] ad, input logic [7:0] tag,
                              input logic [19:0] ew, input logic [63:0] ed,
                              input logic [7:0] et);
    vec_t v;
    v.rst = rst; v.astb = astb; v.atomic = atomic; v.rd = rd; v.wr = wr;
    v.ad = ad; v.tag = tag; v.ew = ew; v.ed = ed; v.et = et;
    vecs.push_back(v);
  endfunction

  localparam logic [63:0] D1 = 64'h1122334455667788;

  initial begin
    logic [19:0] pool [8];
    n_pass = 0; n_total = 0;
    reset = 1'b0; i_ad = '0; i_tag = '0;
    i_astb = 1'b0; i_atomic = 1'b0; i_rd = 1'b0; i_wr = 1'b0;
    m_waddr = '0; m_lock = 1'b0; m_out = '0;

    //   rst astb atm rd wr  ad                    tag     waddr     o_data  o_tag
    add(1, 0, 0, 0, 0, 64'h0,                 8'h00, 20'h0,    64'h0,  8'h00);
    add(0, 1, 0, 0, 0, 64'h5,                 8'h00, 20'h5,    64'h0,  8'h00);
    add(0, 0, 0, 0, 1, D1,                    8'h3C, 20'h5,    64'h0,  8'h00);
    add(0, 1, 0, 0, 0, 64'h5,                 8'h00, 20'h5,    64'h0,  8'h00);
    add(0, 0, 0, 1, 0, 64'h0,                 8'h00, 20'h5,    D1,     8'h3C);
    add(0, 1, 0, 0, 0, 64'hFFFFF_00100,       8'h00, 20'h00100, D1,    8'h3C);
    add(0, 0, 0, 0, 1, 64'hAA,                8'h01, 20'h00100, D1,    8'h3C);
    add(0, 1, 0, 0, 0, 64'h100,               8'h00, 20'h00100, D1,    8'h3C);
    add(0, 0, 0, 1, 0, 64'h0,                 8'h00, 20'h00100, 64'hAA, 8'h01);
    add(0, 1, 0, 0, 0, 64'h7,                 8'h00, 20'h7,    64'hAA, 8'h01);
    add(0, 0, 0, 0, 1, 64'h42,                8'h00, 20'h7,    64'hAA, 8'h01);
    add(0, 1, 0, 0, 0, 64'h0,                 8'h00, 20'h0,    64'hAA, 8'h01);
    add(0, 1, 0, 1, 0, 64'h7,                 8'h00, 20'h7,    64'h42, 8'h00);
    add(0, 1, 0, 0, 1, 64'h7,                 8'h99, 20'h7,    64'h42, 8'h00);
    add(0, 0, 0, 1, 0, 64'h0,                 8'h00, 20'h7,    64'h42, 8'h00);
    add(0, 1, 0, 0, 0, 64'h10,                8'h00, 20'h10,   64'h42, 8'h00);
    add(0, 0, 0, 0, 1, 64'h1,                 8'h00, 20'h10,   64'h42, 8'h00);
    add(0, 1, 1, 0, 0, 64'h10,                8'h00, 20'h10,   64'h42, 8'h00);
    add(0, 0, 0, 1, 0, 64'h0,                 8'h00, 20'h10,   64'h1,  8'h00);
    add(0, 0, 0, 0, 1, 64'h2,                 8'h05, 20'h10,   64'h1,  8'h00);
    add(0, 0, 0, 1, 0, 64'h0,                 8'h00, 20'h10,   64'h2,  8'h05);
    add(0, 1, 0, 0, 0, 64'h20,                8'h00, 20'h20,   64'h2,  8'h05);
    add(0, 0, 0, 0, 1, 64'h9,                 8'h00, 20'h20,   64'h2,  8'h05);
    add(0, 0, 0, 1, 1, 64'hB,                 8'h07, 20'h20,   64'h9,  8'h00);
    add(0, 0, 0, 1, 0, 64'h0,                 8'h00, 20'h20,   64'hB,  8'h07);
    add(0, 1, 0, 0, 0, 64'h3,                 8'h00, 20'h3,    64'hB,  8'h07);
    add(0, 0, 0, 0, 1, 64'h55,                8'h12, 20'h3,    64'hB,  8'h07);
    add(0, 0, 0, 1, 0, 64'h0,                 8'h00, 20'h3,    64'h55, 8'h12);
    add(1, 0, 0, 1, 1, 64'hDEAD,              8'hEE, 20'h0,    64'h0,  8'h00);
    add(0, 1, 0, 0, 0, 64'h3,                 8'h00, 20'h3,    64'h0,  8'h00);
    add(0, 0, 0, 1, 0, 64'h0,                 8'h00, 20'h3,    64'h55, 8'h12);
    add(1, 0, 0, 0, 0, 64'h0,                 8'h00, 20'h0,    64'h0,  8'h00);
    add(0, 0, 0, 0, 1, 64'h77,                8'h0A, 20'h0,    64'h0,  8'h00);
    add(0, 0, 0, 1, 0, 64'h0,                 8'h00, 20'h0,    64'h77, 8'h0A);
    add(0, 1, 1, 0, 0, 64'h10,                8'h00, 20'h10,   64'h77, 8'h0A);
    add(0, 0, 0, 1, 0, 64'h0,                 8'h00, 20'h10,   64'h2,  8'h05);
    add(1, 0, 0, 0, 1, 64'hEE,                8'h0E, 20'h0,    64'h0,  8'h00);
    add(0, 1, 0, 1, 0, 64'h10,                8'h00, 20'h10,   64'h2,  8'h05);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].astb, vecs[i].atomic, vecs[i].rd,
                    vecs[i].wr, vecs[i].ad, vecs[i].tag);
      checkOutput($sformatf("vec%0d", i), vecs[i].ew, vecs[i].ed, vecs[i].et);
    end

    // Randomized phase: seed a pool of addresses so every read is defined.
    pool[0] = 20'h0;     pool[1] = 20'h3;     pool[2] = 20'h7;     pool[3] = 20'h10;
    pool[4] = 20'h20;    pool[5] = 20'h100;   pool[6] = 20'hFFFFF; pool[7] = 20'h2AAAA;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 0, 0, 0, {44'h0, pool[i]}, 8'h00);
      applyStimulus(0, 0, 0, 0, 1, {$urandom, $urandom}, 8'($urandom));
    end

    for (int i = 0; i < 400; i++) begin
      bit          rst, astb, atm, rd, wr;
      logic [63:0] ad;
      rst  = ($urandom_range(39) == 0);
      astb = ($urandom_range(3) == 0);
      atm  = astb && $urandom_range(1) == 1;
      rd   = $urandom_range(1) == 1;
      wr   = $urandom_range(2) == 0;
      ad   = astb ? {$urandom, 12'($urandom), pool[$urandom_range(7)]}
                  : {$urandom, $urandom};
      applyStimulus(rst, astb, atm, rd, wr, ad, 8'($urandom));
      checkOutput($sformatf("rand%0d", i), m_waddr, m_out.data, m_out.tag);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
